// File: rtl/pkg_en.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_en
//  Description : Shared ElectronNest link types (forward/backward tokens),
//                data/address widths and the ext_mem_port state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package pkg_en;

   localparam int WIDTH_DATA       = 32;
   localparam int WIDTH_EXADDR     = 10;

   // Cycles between a load request and its returned word.
   localparam int EXMEM_LD_LATENCY = 1;

   // Forward token: v=valid, a=first word, r=last word, c=config, i=indirect.
   typedef struct packed {
      logic                  v;
      logic                  a;
      logic                  r;
      logic                  c;
      logic                  i;
      logic [WIDTH_DATA-1:0] d;
   } FTk_t;

   // Backward token: n=not accepted, t=auxiliary flag.
   typedef struct packed {
      logic n;
      logic t;
   } BTk_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LD_RUN   = 3'd1,
      LD_DRAIN = 3'd2,
      ST_RUN   = 3'd3,
      DONE     = 3'd4
   } ext_mem_state_t;

endpackage
`default_nettype wire

// File: rtl/ext_mem_skid.sv
`default_nettype none
// ============================================================================
//  Module      : ext_mem_skid
//  Description : Small FIFO of FTk_t that absorbs load returns while the
//                fabric side is backpressured.
//  Ports       : clock, reset (async active-low)
//                push_i/data_i : write one entry
//                pop_i/data_o  : head entry, removed on pop_i
//                empty_o/occ_o : status
//  Revision    : 1.0  initial release
// ============================================================================
module ext_mem_skid
   import pkg_en::*;
#(
   parameter int DEPTH = 2,
   parameter int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  FTk_t             data_i,
   input  logic             pop_i,
   output FTk_t             data_o,
   output logic             empty_o,
   output logic [OCC_W-1:0] occ_o
);

   localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

   FTk_t             mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [OCC_W-1:0] occ_q;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop_i & (occ_q != '0);
   // A full buffer can still take a word when the head leaves this cycle.
   assign do_push = push_i & ((occ_q != OCC_W'(DEPTH)) | do_pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign empty_o = (occ_q == '0);
   assign occ_o   = occ_q;

endmodule
`default_nettype wire

// File: rtl/ext_mem_port.sv
`default_nettype none
// ============================================================================
//  Module      : ext_mem_port
//  Description : Block-transfer initiator toward an external memory
//                Load/Store responder. One command at a time; loads stream
//                returned words to the fabric, stores drain fabric tokens.
//  Ports       : clock, reset (async active-low)
//                I_Cmd_*/O_Cmd_Ready/O_Done  : command handshake
//                O_FTk/I_BTk                 : load data toward fabric
//                I_FTk/O_BTk                 : store data from fabric
//                O_Ld_*/I_Ld_FTk/O_Ld_BTk    : memory load channel
//                O_St_*/I_St_BTk             : memory store channel
//  Revision    : 1.0  initial release
// ============================================================================
module ext_mem_port
   import pkg_en::*;
#(
   parameter int WIDTH_LEN  = 10,
   parameter int DEPTH_SKID = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    I_Cmd_Valid,
   input  logic                    I_Cmd_Dir,
   input  logic [WIDTH_EXADDR-1:0] I_Cmd_Base,
   input  logic [WIDTH_LEN-1:0]    I_Cmd_Len,
   output logic                    O_Cmd_Ready,
   output logic                    O_Done,
   output FTk_t                    O_FTk,
   input  BTk_t                    I_BTk,
   input  FTk_t                    I_FTk,
   output BTk_t                    O_BTk,
   output logic                    O_Ld_Req,
   output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
   input  FTk_t                    I_Ld_FTk,
   output BTk_t                    O_Ld_BTk,
   output logic                    O_St_Req,
   output logic [WIDTH_EXADDR-1:0] O_St_Addr,
   output FTk_t                    O_St_FTk,
   input  BTk_t                    I_St_BTk
);

   localparam int OCC_W = $clog2(DEPTH_SKID + 1);

   ext_mem_state_t          state_q,    state_d;
   logic [WIDTH_EXADDR-1:0] base_q,     base_d;
   logic [WIDTH_LEN-1:0]    len_q,      len_d;
   logic [WIDTH_LEN-1:0]    issued_q,   issued_d;
   logic [WIDTH_LEN-1:0]    sent_q,     sent_d;
   logic [WIDTH_LEN-1:0]    addr_cnt_q, addr_cnt_d;
   logic                    inflight_q;
   logic                    cmd_ready_q;
   logic                    done_q;

   FTk_t                    skid_head;
   logic                    skid_empty;
   logic [OCC_W-1:0]        skid_occ;
   logic [31:0]             pending;
   logic                    ld_req;
   logic                    ld_push;
   logic                    ld_pop;
   logic                    st_xfer;
   logic                    in_ld;

   assign in_ld   = (state_q == LD_RUN) || (state_q == LD_DRAIN);
   // Words held plus the one possibly still on its way back must fit.
   assign pending = 32'(skid_occ) + 32'(inflight_q);
   assign ld_req  = (state_q == LD_RUN) && (issued_q < len_q) && (pending < 32'(DEPTH_SKID));
   // Returns are only honoured when a request went out the previous cycle.
   assign ld_push = in_ld & inflight_q & I_Ld_FTk.v;
   assign ld_pop  = ~skid_empty & ~I_BTk.n;
   assign st_xfer = (state_q == ST_RUN) & I_FTk.v & ~I_St_BTk.n;

   ext_mem_skid #(
      .DEPTH (DEPTH_SKID),
      .OCC_W (OCC_W)
   ) u_skid (
      .clock   (clock),
      .reset   (reset),
      .push_i  (ld_push),
      .data_i  (I_Ld_FTk),
      .pop_i   (ld_pop),
      .data_o  (skid_head),
      .empty_o (skid_empty),
      .occ_o   (skid_occ)
   );

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      issued_d   = issued_q;
      sent_d     = sent_q;
      addr_cnt_d = addr_cnt_q;

      if (ld_pop) sent_d = sent_q + WIDTH_LEN'(1);

      case (state_q)
         IDLE: begin
            if (I_Cmd_Valid) begin
               base_d     = I_Cmd_Base;
               len_d      = I_Cmd_Len;
               issued_d   = '0;
               sent_d     = '0;
               addr_cnt_d = '0;
               if (I_Cmd_Len == '0)  state_d = DONE;
               else if (I_Cmd_Dir)   state_d = ST_RUN;
               else                  state_d = LD_RUN;
            end
         end
         LD_RUN: begin
            if (ld_req) issued_d = issued_q + WIDTH_LEN'(1);
            if (issued_d == len_q) state_d = LD_DRAIN;
         end
         LD_DRAIN: begin
            if ((sent_q == len_q) && skid_empty) state_d = DONE;
         end
         ST_RUN: begin
            if (st_xfer) addr_cnt_d = addr_cnt_q + WIDTH_LEN'(1);
            if (addr_cnt_d == len_q) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         sent_q      <= '0;
         addr_cnt_q  <= '0;
         inflight_q  <= 1'b0;
         cmd_ready_q <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         sent_q      <= sent_d;
         addr_cnt_q  <= addr_cnt_d;
         inflight_q  <= ld_req;
         cmd_ready_q <= (state_d == IDLE);
         done_q      <= (state_d == DONE);
      end
   end

   assign O_Cmd_Ready = cmd_ready_q;
   assign O_Done      = done_q;

   assign O_Ld_Req  = ld_req;
   assign O_Ld_Addr = base_q + WIDTH_EXADDR'(issued_q);
   assign O_Ld_BTk  = '0;

   always_comb begin
      O_FTk = '0;
      if (!skid_empty) begin
         O_FTk.v = 1'b1;
         O_FTk.a = (sent_q == '0);
         O_FTk.r = (sent_q == (len_q - WIDTH_LEN'(1)));
         O_FTk.d = skid_head.d;
      end
   end

   // Store path is a straight pass-through; stores stall exactly as memory does.
   always_comb begin
      O_BTk    = '0;
      O_BTk.n  = (state_q == ST_RUN) ? I_St_BTk.n : 1'b1;
      O_St_FTk = (state_q == ST_RUN) ? I_FTk : '0;
   end
   assign O_St_Req  = (state_q == ST_RUN) & I_FTk.v;
   assign O_St_Addr = base_q + WIDTH_EXADDR'(addr_cnt_q);

   logic unused_bits;
   assign unused_bits = ^{I_BTk.t, I_St_BTk.t, I_Ld_FTk.a, I_Ld_FTk.r, I_Ld_FTk.c,
                          I_Ld_FTk.i, skid_head.v, skid_head.a, skid_head.r,
                          skid_head.c, skid_head.i};

endmodule
`default_nettype wire
